// File: rtl/pixel_frame_sequencer.sv
// Frame-level sequencer for the pixel array: erase -> expose -> convert ->
// read1 -> read2, with a one-cycle guard between phases.
// It also generates the ADC ramp code during convert and steps row addresses
// to the readout consumer during both read phases.
//
// Row handshake (valid/ready): rd_valid is high for the whole of READ1/READ2.
// A row transfers at a clock edge where rd_valid & rd_ready are both 1.
// While rd_ready is 0, rd_valid and rd_row hold their values.
// The consumer may hold rd_ready low for as long as it likes; there is no timeout.
module pixel_frame_sequencer #(
  parameter int C_ERASE = 5,
  parameter int RAMP_W  = 8,
  parameter int N_ROWS  = 16,
  parameter int ROW_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic [7:0]        expose_time,
  input  logic              rd_ready,
  output logic              erase,
  output logic              expose,
  output logic              convert,
  output logic              read1,
  output logic              read2,
  output logic [RAMP_W-1:0] ramp,
  output logic              rd_valid,
  output logic [ROW_W-1:0]  rd_row,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        dbg_state
);

  localparam int CW = ((RAMP_W > 8) ? RAMP_W : 8) + 1;

  localparam logic [CW-1:0]    ERASE_LAST = CW'(C_ERASE - 1);
  localparam logic [CW-1:0]    RAMP_LAST  = CW'((2 ** RAMP_W) - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(N_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ1   = 3'd4,
    S_READ2   = 3'd5,
    S_GUARD   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  state_t            nxt_q, nxt_d;        // phase entered after the guard cycle
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [7:0]        exp_q, exp_d;        // expose time latched for this frame
  logic              done_d;
  logic [CW-1:0]     exp_last;

  // A zero expose time still gives one expose cycle.
  assign exp_last = (exp_q == 8'd0) ? '0 : (CW'(exp_q) - CW'(1));

  // Next-state logic: phase sequencing, counters, row stepping, abort
  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    cnt_d   = cnt_q + CW'(1);
    row_d   = row_q;
    exp_d   = exp_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start && !abort) begin
          state_d = S_ERASE;
          exp_d   = expose_time;
        end
      end
      S_ERASE: begin
        if (cnt_q == ERASE_LAST) begin
          state_d = S_GUARD;
          nxt_d   = S_EXPOSE;
          cnt_d   = '0;
        end
      end
      S_EXPOSE: begin
        if (cnt_q == exp_last) begin
          state_d = S_GUARD;
          nxt_d   = S_CONVERT;
          cnt_d   = '0;
        end
      end
      S_CONVERT: begin
        if (cnt_q == RAMP_LAST) begin
          state_d = S_GUARD;
          nxt_d   = S_READ1;
          cnt_d   = '0;
        end
      end
      S_READ1: begin
        cnt_d = '0;
        if (rd_ready) begin
          if (row_q == ROW_LAST) begin
            state_d = S_GUARD;
            nxt_d   = S_READ2;
            row_d   = '0;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      S_READ2: begin
        cnt_d = '0;
        if (rd_ready) begin
          if (row_q == ROW_LAST) begin
            state_d = S_GUARD;
            row_d   = '0;
            done_d  = 1'b1;
            if (continuous) begin
              nxt_d = S_ERASE;
              exp_d = expose_time;
            end else begin
              nxt_d = S_IDLE;
            end
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      S_GUARD: begin
        state_d = nxt_q;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort wins over any phase end or handshake in the same cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      nxt_d   = S_IDLE;
      cnt_d   = '0;
      row_d   = '0;
      done_d  = 1'b0;
    end
  end

  // State, counters and Moore outputs decoded from the next state, all registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      nxt_q      <= S_IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      exp_q      <= '0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      read1      <= 1'b0;
      read2      <= 1'b0;
      ramp       <= '0;
      rd_valid   <= 1'b0;
      rd_row     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      nxt_q      <= nxt_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      exp_q      <= exp_d;
      erase      <= (state_d == S_ERASE);
      expose     <= (state_d == S_EXPOSE);
      convert    <= (state_d == S_CONVERT);
      read1      <= (state_d == S_READ1);
      read2      <= (state_d == S_READ2);
      ramp       <= (state_d == S_CONVERT) ? cnt_d[RAMP_W-1:0] : '0;
      rd_valid   <= (state_d == S_READ1) || (state_d == S_READ2);
      rd_row     <= ((state_d == S_READ1) || (state_d == S_READ2)) ? row_d : '0;
      busy       <= (state_d != S_IDLE);
      frame_done <= done_d;
    end
  end

  assign dbg_state = state_q;

endmodule
